mem_access_stage: RTL and testbench

- Memory stage of the 5-stage RISC-V pipeline. Consumes the M-side outputs of the execute→memory pipeline register and performs data-memory loads and stores over a req/ack handshake.
- Aligns store data to byte lanes and extracts and extends load data.
- Drives the memory→writeback pipeline register and raises a stall to the hazard unit while an access is outstanding.

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/mem_access_stage_lane_align.sv | 60 ++++++
 rtl/mem_access_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Types and constants shared by the RISC-V memory-access stage.
//   DPW          : datapath width (32 only)
//   F3_*         : funct3 encodings for load/store size and sign
//   mem_state_t  : memory-stage handshake FSM states
//   mw_reg_t     : fields of the memory->writeback pipeline register
//   is_misaligned: address alignment check for a given access size
// Optional macro MEM_TIMEOUT_EN adds the bus-error flag to mw_reg_t.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int DPW = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic           valid;
        logic           regwrite;
        logic           resultsrc;
        logic [DPW-1:0] aluresult;
        logic [DPW-1:0] readdata;
        logic [4:0]     rd;
        logic           misalign;
`ifdef MEM_TIMEOUT_EN
        logic           buserr;
`endif
    } mw_reg_t;

    // Halfwords need bit 0 clear, words need both low bits clear; bytes are
    // always aligned.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] off);
        logic res;
        case (f3[1:0])
            2'b01:   res = off[0];
            2'b10:   res = (off != 2'b00);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane logic for the memory stage.
//   funct3     in  access size/sign
//   byte_off   in  low two address bits
//   store_data in  register value to be stored
//   rdata      in  word returned by data memory
//   wdata      out store data replicated onto every lane it may occupy
//   store_be   out byte enables for a store
//   load_data  out selected bytes of rdata, sign/zero extended
// ---------------------------------------------------------------------------
module mem_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]     funct3,
    input  logic [1:0]     byte_off,
    input  logic [DPW-1:0] store_data,
    input  logic [DPW-1:0] rdata,
    output logic [DPW-1:0] wdata,
    output logic [3:0]     store_be,
    output logic [DPW-1:0] load_data
);

    logic [DPW-1:0] shifted_s;

    // Store lane replication and byte-enable generation.
    always_comb begin
        wdata    = store_data;
        store_be = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata    = {4{store_data[7:0]}};
                store_be = 4'b0001 << byte_off;
            end
            2'b01: begin
                wdata    = {2{store_data[15:0]}};
                store_be = byte_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata    = store_data;
                store_be = 4'b1111;
            end
        endcase
    end

    // Bring the addressed byte/halfword down to bit 0, then extend.
    always_comb begin
        shifted_s = rdata >> {byte_off, 3'b000};
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'h000000, shifted_s[7:0]};
            F3_HU:   load_data = {16'h0000, shifted_s[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// Memory stage of a 5-stage RISC-V pipeline: issues data-memory loads and
// stores over a req/ack handshake, stalls upstream while an access is
// outstanding, and drives the memory->writeback pipeline register.
//   clk, rst_n            clock / async active-low reset
//   validM..RdM           execute->memory register fields (held while stalled)
//   dmem_req/we/addr/     data-memory request; driven combinationally from the
//   wdata/be              M fields, which stay frozen during a stall
//   dmem_ack/rdata        completion and read word
//   stall_mem             freezes IF/ID/EX and the E-M register
//   validW..misalignW     registered writeback fields
//   buserrW               (MEM_TIMEOUT_EN only) access abandoned on timeout
// Optional macro MEM_TIMEOUT_EN: abandon an access after TIMEOUT cycles
// without ack and report a bus error instead of waiting forever.
// ---------------------------------------------------------------------------
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int DPW     = 32,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           validM,
    input  logic           regwriteM,
    input  logic           resultsrcM,
    input  logic           memwriteM,
    input  logic [2:0]     funct3M,
    input  logic [DPW-1:0] aluresultM,
    input  logic [DPW-1:0] Rd2M,
    input  logic [4:0]     RdM,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [DPW-1:0] dmem_addr,
    output logic [DPW-1:0] dmem_wdata,
    output logic [3:0]     dmem_be,
    input  logic           dmem_ack,
    input  logic [DPW-1:0] dmem_rdata,
    output logic           stall_mem,
    output logic           validW,
    output logic           regwriteW,
    output logic           resultsrcW,
    output logic [DPW-1:0] aluresultW,
    output logic [DPW-1:0] readdataW,
    output logic [4:0]     RdW,
    output logic           misalignW
`ifdef MEM_TIMEOUT_EN
    ,
    output logic           buserrW
`endif
);

    if (DPW != 32) begin : g_dpw_check
        $error("mem_access_stage: only DPW = 32 is supported");
    end
    if (TIMEOUT < 2) begin : g_timeout_check
        $error("mem_access_stage: TIMEOUT must be at least 2");
    end

    mem_state_t     state_r;
    mem_state_t     state_next_s;
    mw_reg_t        w_r;
    mw_reg_t        w_next_s;
    logic           memop_s;
    logic           misal_s;
    logic           req_s;
    logic           stall_s;
    logic           tout_s;
    logic [DPW-1:0] wdata_s;
    logic [3:0]     store_be_s;
    logic [DPW-1:0] load_data_s;

    assign memop_s = validM & (memwriteM | resultsrcM);
    assign misal_s = memop_s & is_misaligned(funct3M, aluresultM[1:0]);

    mem_lane_align u_lane (
        .funct3     (funct3M),
        .byte_off   (aluresultM[1:0]),
        .store_data (Rd2M),
        .rdata      (dmem_rdata),
        .wdata      (wdata_s),
        .store_be   (store_be_s),
        .load_data  (load_data_s)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_r;

    // Cycles spent in WAIT; zero on the first WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= '0;
        end
    end
`endif

    // Handshake FSM next state, request and timeout decode. Reset gates the
    // request so it drops at once even mid-access.
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        tout_s       = 1'b0;
        if (!rst_n) begin
            state_next_s = IDLE;
            req_s        = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    req_s = memop_s & ~misal_s;
                    if (req_s && !dmem_ack) begin
                        state_next_s = WAIT;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                WAIT: begin
`ifdef MEM_TIMEOUT_EN
                    if (dmem_ack) begin
                        req_s        = 1'b1;
                        state_next_s = IDLE;
                    end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                        // Give up: this cycle completes the instruction
                        // with a bus error instead of data.
                        req_s        = 1'b0;
                        tout_s       = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        req_s        = 1'b1;
                        state_next_s = WAIT;
                    end
`else
                    req_s = 1'b1;
                    if (dmem_ack) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = WAIT;
                    end
`endif
                end
                default: begin
                    state_next_s = IDLE;
                    req_s        = 1'b0;
                end
            endcase
        end
    end

    assign stall_s = req_s & ~dmem_ack;

    // Next contents of the writeback register; a bubble unless the M-stage
    // instruction completes this cycle.
    always_comb begin
        w_next_s = '0;
        if (stall_s || !validM) begin
            w_next_s = '0;
        end else if (misal_s) begin
            w_next_s.valid     = 1'b1;
            w_next_s.regwrite  = 1'b0;
            w_next_s.resultsrc = resultsrcM;
            w_next_s.aluresult = aluresultM;
            w_next_s.rd        = RdM;
            w_next_s.misalign  = 1'b1;
        end else if (tout_s) begin
            w_next_s.valid     = 1'b1;
            w_next_s.regwrite  = 1'b0;
            w_next_s.resultsrc = resultsrcM;
            w_next_s.aluresult = aluresultM;
            w_next_s.rd        = RdM;
`ifdef MEM_TIMEOUT_EN
            w_next_s.buserr    = 1'b1;
`endif
        end else begin
            w_next_s.valid     = 1'b1;
            w_next_s.regwrite  = regwriteM;
            w_next_s.resultsrc = resultsrcM;
            w_next_s.aluresult = aluresultM;
            w_next_s.rd        = RdM;
            if (memop_s && resultsrcM) begin
                w_next_s.readdata = load_data_s;
            end else begin
                w_next_s.readdata = '0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory->writeback pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_r <= '0;
        end else begin
            w_r <= w_next_s;
        end
    end

    assign dmem_req   = req_s;
    assign dmem_we    = req_s & memwriteM;
    assign dmem_addr  = {aluresultM[DPW-1:2], 2'b00};
    assign dmem_wdata = wdata_s;
    assign dmem_be    = memwriteM ? store_be_s : 4'b1111;
    assign stall_mem  = stall_s;

    assign validW     = w_r.valid;
    assign regwriteW  = w_r.regwrite;
    assign resultsrcW = w_r.resultsrc;
    assign aluresultW = w_r.aluresult;
    assign readdataW  = w_r.readdata;
    assign RdW        = w_r.rd;
    assign misalignW  = w_r.misalign;
`ifdef MEM_TIMEOUT_EN
    assign buserrW    = w_r.buserr;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
// Directed bench for mem_access_stage: single-cycle vectors from a table,
// then hand-written multi-cycle sequences (wait states, reset mid-access,
// and the timeout path when MEM_TIMEOUT_EN is defined).
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        validM, regwriteM, resultsrcM, memwriteM;
    logic [2:0]  funct3M;
    logic [31:0] aluresultM, Rd2M;
    logic [4:0]  RdM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_mem;
    logic        validW, regwriteW, resultsrcW;
    logic [31:0] aluresultW, readdataW;
    logic [4:0]  RdW;
    logic        misalignW;
`ifdef MEM_TIMEOUT_EN
    logic        buserrW;
`endif

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.DPW(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .validM     (validM),
        .regwriteM  (regwriteM),
        .resultsrcM (resultsrcM),
        .memwriteM  (memwriteM),
        .funct3M    (funct3M),
        .aluresultM (aluresultM),
        .Rd2M       (Rd2M),
        .RdM        (RdM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .stall_mem  (stall_mem),
        .validW     (validW),
        .regwriteW  (regwriteW),
        .resultsrcW (resultsrcW),
        .aluresultW (aluresultW),
        .readdataW  (readdataW),
        .RdW        (RdW),
        .misalignW  (misalignW)
`ifdef MEM_TIMEOUT_EN
        ,
        .buserrW    (buserrW)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        vm, rw, rs, mw;
        logic [2:0]  f3;
        logic [31:0] alu, rd2;
        logic [4:0]  rd;
        logic        ack;
        logic [31:0] rdata;
        logic        ereq, ewe;
        logic [3:0]  ebe;
        logic [31:0] ewdata;
        logic        evw, erw, emis;
        logic [31:0] erdw;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        validM     = v.vm;
        regwriteM  = v.rw;
        resultsrcM = v.rs;
        memwriteM  = v.mw;
        funct3M    = v.f3;
        aluresultM = v.alu;
        Rd2M       = v.rd2;
        RdM        = v.rd;
        dmem_ack   = v.ack;
        dmem_rdata = v.rdata;
    endtask

    task automatic op(input logic vm, input logic rw, input logic rs, input logic mw,
                      input logic [2:0] f3, input logic [31:0] alu, input logic [4:0] rd);
        validM     = vm;
        regwriteM  = rw;
        resultsrcM = rs;
        memwriteM  = mw;
        funct3M    = f3;
        aluresultM = alu;
        Rd2M       = 32'h0;
        RdM        = rd;
    endtask

    vec_t vecs[13];
    int   stall_cnt;

    initial begin
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b1,3'b010,32'h100,32'hDEADBEEF,5'd0,1'b1,32'h0,
                     1'b1,1'b1,4'hF,32'hDEADBEEF,1'b1,1'b0,1'b0,32'h0,"sw"};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,3'b001,32'h102,32'h1234ABCD,5'd0,1'b1,32'h0,
                     1'b1,1'b1,4'hC,32'hABCDABCD,1'b1,1'b0,1'b0,32'h0,"sh"};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,3'b000,32'h101,32'h000000A5,5'd0,1'b1,32'h0,
                     1'b1,1'b1,4'h2,32'hA5A5A5A5,1'b1,1'b0,1'b0,32'h0,"sb"};
        vecs[3]  = '{1'b1,1'b1,1'b1,1'b0,3'b101,32'h102,32'h0,5'd5,1'b1,32'hF00D0000,
                     1'b1,1'b0,4'hF,32'h0,1'b1,1'b1,1'b0,32'h0000F00D,"lhu"};
        vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,3'b010,32'h104,32'h0,5'd6,1'b1,32'h12345678,
                     1'b1,1'b0,4'hF,32'h0,1'b1,1'b1,1'b0,32'h12345678,"lw"};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,3'b001,32'h100,32'h0,5'd7,1'b1,32'h00008001,
                     1'b1,1'b0,4'hF,32'h0,1'b1,1'b1,1'b0,32'hFFFF8001,"lh0"};
        vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,3'b100,32'h101,32'h0,5'd8,1'b1,32'h00009A00,
                     1'b1,1'b0,4'hF,32'h0,1'b1,1'b1,1'b0,32'h0000009A,"lbu1"};
        vecs[7]  = '{1'b1,1'b1,1'b1,1'b0,3'b000,32'h102,32'h0,5'd9,1'b1,32'h007F0000,
                     1'b1,1'b0,4'hF,32'h0,1'b1,1'b1,1'b0,32'h0000007F,"lb2"};
        vecs[8]  = '{1'b1,1'b1,1'b1,1'b0,3'b001,32'h102,32'h0,5'd10,1'b1,32'hC0DE0000,
                     1'b1,1'b0,4'hF,32'h0,1'b1,1'b1,1'b0,32'hFFFFC0DE,"lh2"};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b0,3'b000,32'hCAFEF00D,32'h0,5'd11,1'b0,32'h0,
                     1'b0,1'b0,4'hF,32'h0,1'b1,1'b1,1'b0,32'h0,"alu"};
        vecs[10] = '{1'b1,1'b1,1'b1,1'b0,3'b010,32'h101,32'h0,5'd12,1'b0,32'h0,
                     1'b0,1'b0,4'hF,32'h0,1'b1,1'b0,1'b1,32'h0,"lw_mis"};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b1,3'b001,32'h103,32'h5555,5'd0,1'b0,32'h0,
                     1'b0,1'b0,4'h0,32'h0,1'b1,1'b0,1'b1,32'h0,"sh_mis"};
        vecs[12] = '{1'b0,1'b1,1'b1,1'b0,3'b010,32'h200,32'h0,5'd13,1'b1,32'hFFFFFFFF,
                     1'b0,1'b0,4'h0,32'h0,1'b0,1'b0,1'b0,32'h0,"bubble"};

        // Reset with a live load presented: no request may escape.
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 5'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_stall", {31'b0, stall_mem}, 32'h0);
        chk("rst_validW", {31'b0, validW}, 32'h0);
        chk("rst_regwriteW", {31'b0, regwriteW}, 32'h0);
        chk("rst_readdataW", readdataW, 32'h0);
        chk("rst_aluresultW", aluresultW, 32'h0);
        validM = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk); #1;

        // Single-cycle table: ack (if any) in the request cycle.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk({vecs[i].name, "_req"}, {31'b0, dmem_req}, {31'b0, vecs[i].ereq});
            chk({vecs[i].name, "_stall"}, {31'b0, stall_mem}, 32'h0);
            chk({vecs[i].name, "_we"}, {31'b0, dmem_we}, {31'b0, vecs[i].ewe});
            if (vecs[i].ereq) begin
                chk({vecs[i].name, "_be"}, {28'b0, dmem_be}, {28'b0, vecs[i].ebe});
                chk({vecs[i].name, "_addr"}, dmem_addr, vecs[i].alu & 32'hFFFFFFFC);
            end
            if (vecs[i].ewe) begin
                chk({vecs[i].name, "_wdata"}, dmem_wdata, vecs[i].ewdata);
            end
            @(posedge clk); #1;
            chk({vecs[i].name, "_validW"}, {31'b0, validW}, {31'b0, vecs[i].evw});
            chk({vecs[i].name, "_regwriteW"}, {31'b0, regwriteW}, {31'b0, vecs[i].erw});
            chk({vecs[i].name, "_misalignW"}, {31'b0, misalignW}, {31'b0, vecs[i].emis});
            chk({vecs[i].name, "_readdataW"}, readdataW, vecs[i].erdw);
            chk({vecs[i].name, "_aluresultW"}, aluresultW, vecs[i].evw ? vecs[i].alu : 32'h0);
            chk({vecs[i].name, "_RdW"}, {27'b0, RdW}, vecs[i].evw ? {27'b0, vecs[i].rd} : 32'h0);
        end

        // lb from 0x103 with ack three cycles late: three stall cycles of bubbles.
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 5'd3);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        stall_cnt  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (stall_mem) stall_cnt++;
            chk("lbw_req_held", {31'b0, dmem_req}, 32'h1);
            chk("lbw_addr_held", dmem_addr, 32'h100);
            @(posedge clk); #1;
            chk("lbw_bubble", {31'b0, validW}, 32'h0);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF0000;
        @(negedge clk);
        chk("lbw_stall_ack", {31'b0, stall_mem}, 32'h0);
        chk("lbw_stall_cycles", stall_cnt, 32'd3);
        @(posedge clk); #1;
        chk("lbw_readdataW", readdataW, 32'hFFFFFF80);
        chk("lbw_regwriteW", {31'b0, regwriteW}, 32'h1);
        chk("lbw_validW", {31'b0, validW}, 32'h1);
        chk("lbw_RdW", {27'b0, RdW}, 32'd3);
        validM   = 1'b0;
        dmem_ack = 1'b0;

        // Reset during the second WAIT cycle, then a late ack that must be ignored.
        @(posedge clk); #1;
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h108, 5'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rw_req_before", {31'b0, dmem_req}, 32'h1);
        chk("rw_stall_before", {31'b0, stall_mem}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rw_req_drop", {31'b0, dmem_req}, 32'h0);
        chk("rw_stall_drop", {31'b0, stall_mem}, 32'h0);
        chk("rw_validW", {31'b0, validW}, 32'h0);
        chk("rw_readdataW", readdataW, 32'h0);
        @(negedge clk);
        validM = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk); #1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55AA55AA;
        @(negedge clk);
        chk("rw_late_req", {31'b0, dmem_req}, 32'h0);
        chk("rw_late_stall", {31'b0, stall_mem}, 32'h0);
        @(posedge clk); #1;
        chk("rw_late_validW", {31'b0, validW}, 32'h0);
        chk("rw_late_readdataW", readdataW, 32'h0);
        dmem_ack = 1'b0;
        // ALU op after reset: an FSM left in WAIT would still request.
        op(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h00001234, 5'd14);
        @(negedge clk);
        chk("rw_idle_req", {31'b0, dmem_req}, 32'h0);
        chk("rw_idle_stall", {31'b0, stall_mem}, 32'h0);
        @(posedge clk); #1;
        chk("rw_idle_validW", {31'b0, validW}, 32'h1);
        chk("rw_idle_aluresultW", aluresultW, 32'h00001234);
        validM = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // Load never acknowledged: four stall cycles, then a bus error.
        @(posedge clk); #1;
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h10C, 5'd15);
        stall_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!stall_mem) break;
            stall_cnt++;
            @(posedge clk); #1;
        end
        chk("to_stall_cycles", stall_cnt, 32'd4);
        chk("to_req_drop", {31'b0, dmem_req}, 32'h0);
        @(posedge clk); #1;
        chk("to_buserrW", {31'b0, buserrW}, 32'h1);
        chk("to_regwriteW", {31'b0, regwriteW}, 32'h0);
        chk("to_validW", {31'b0, validW}, 32'h1);
        validM = 1'b0;
        @(posedge clk); #1;
        chk("to_buserr_clear", {31'b0, buserrW}, 32'h0);
        chk("to_stall_clear", {31'b0, stall_mem}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
